// File: rtl/val2_shift_pipe.sv
// val2_shift_pipe: pipelined ARM operand-2 generator (immediate rotate, shifts, memory offset)
// with valid/ready buffering over 1 or 2 register stages.
module val2_shift_pipe #(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 1,
    parameter bit MEM_SEXT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Val_Rm,
    input  logic [WIDTH-1:0] Val_Rs,
    input  logic [11:0]      Shift_operand,
    input  logic             imm,
    input  logic             MEM,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Val2,
    output logic             carry_out
);

    localparam int               SW     = 2 * WIDTH + 1;
    localparam logic [7:0]       W8     = 8'(WIDTH);
    localparam logic [7:0]       W_MASK = 8'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    // Every operation is expressed as a right funnel shift of a (2*WIDTH+1)-bit source:
    // result = src[amt+1 +: WIDTH]; carry = src[amt] (right shifts) or src[amt+WIDTH+1] (LSL).
    typedef struct packed {
        logic [SW-1:0] src;
        logic [7:0]    amt;
        logic          left;
    } shf_t;

    function automatic shf_t f_pass(input logic [WIDTH-1:0] v, input logic c);
        shf_t r;
        r.src  = {ZERO_W, v, c};
        r.amt  = 8'd0;
        r.left = 1'b0;
        return r;
    endfunction

    function automatic shf_t f_lsr(input logic [WIDTH-1:0] rm, input logic [7:0] n, input logic c);
        shf_t r;
        r.src  = {ZERO_W, rm, c};
        r.amt  = n;
        r.left = 1'b0;
        return r;
    endfunction

    function automatic shf_t f_asr(input logic [WIDTH-1:0] rm, input logic [7:0] n, input logic c);
        shf_t r;
        r.src  = {{WIDTH{rm[WIDTH-1]}}, rm, c};
        r.amt  = n;
        r.left = 1'b0;
        return r;
    endfunction

    function automatic shf_t f_ror(input logic [WIDTH-1:0] rm, input logic [7:0] n, input logic c);
        shf_t r;
        r.src  = {rm, rm, c};
        r.amt  = n;
        r.left = 1'b0;
        return r;
    endfunction

    // Left shift by n == right funnel of {rm, 0} by WIDTH-n; carry is the bit just above.
    function automatic shf_t f_lsl(input logic [WIDTH-1:0] rm, input logic [7:0] n, input logic c);
        shf_t r;
        r.src  = {rm, ZERO_W, c};
        r.amt  = W8 - n;
        r.left = 1'b1;
        return r;
    endfunction

    function automatic logic [WIDTH:0] f_select(input shf_t p);
        logic [SW-1:0] sh;
        sh = p.src >> p.amt;
        return {(p.left ? sh[WIDTH+1] : sh[0]), sh[WIDTH:1]};
    endfunction

    logic [WIDTH-1:0] mem_ext_s;
    logic [WIDTH-1:0] imm_ext_s;
    logic [7:0]       ish_amt_s;
    logic [7:0]       rs_amt_s;
    logic [7:0]       ror_amt_s;
    logic [7:0]       rot_s;
    shf_t             ish_s;
    shf_t             rsh_s;
    shf_t             dec_s;
    shf_t             out_src_s;
    logic             out_load_s;
    logic             out_free_s;
    logic             in_ready_s;
    logic [WIDTH:0]   sel_s;
    logic             unused_rs_s;

    logic             vo_q, vo_d;
    logic [WIDTH-1:0] val2_q, val2_d;
    logic             co_q, co_d;

    assign mem_ext_s   = MEM_SEXT ? {{(WIDTH-12){Shift_operand[11]}}, Shift_operand}
                                  : {{(WIDTH-12){1'b0}}, Shift_operand};
    assign imm_ext_s   = {{(WIDTH-8){1'b0}}, Shift_operand[7:0]};
    assign rot_s       = {3'b000, Shift_operand[11:8], 1'b0};
    assign ish_amt_s   = {3'b000, Shift_operand[11:7]};
    assign rs_amt_s    = Val_Rs[7:0];
    assign ror_amt_s   = rs_amt_s & W_MASK;
    assign unused_rs_s = ^Val_Rs[WIDTH-1:8];

    // Immediate-amount shift decode; amount 0 selects the LSR/ASR #32 and RRX encodings.
    always_comb begin
        ish_s = f_pass(Val_Rm, carry_in);
        case (Shift_operand[6:5])
            2'b00:   ish_s = (ish_amt_s == 8'd0) ? f_pass(Val_Rm, carry_in)
                                                 : f_lsl(Val_Rm, ish_amt_s, carry_in);
            2'b01:   ish_s = f_lsr(Val_Rm, (ish_amt_s == 8'd0) ? 8'd32 : ish_amt_s, carry_in);
            2'b10:   ish_s = f_asr(Val_Rm, (ish_amt_s == 8'd0) ? 8'd32 : ish_amt_s, carry_in);
            2'b11:   ish_s = (ish_amt_s == 8'd0) ? f_pass({carry_in, Val_Rm[WIDTH-1:1]}, Val_Rm[0])
                                                 : f_ror(Val_Rm, ish_amt_s, carry_in);
            default: ish_s = f_pass(Val_Rm, carry_in);
        endcase
    end

    // Register-specified shift decode on the low byte of Rs.
    always_comb begin
        rsh_s = f_pass(Val_Rm, carry_in);
        if (rs_amt_s == 8'd0) begin
            rsh_s = f_pass(Val_Rm, carry_in);
        end else begin
            case (Shift_operand[6:5])
                2'b00:   rsh_s = (rs_amt_s <= W8) ? f_lsl(Val_Rm, rs_amt_s, carry_in)
                                                  : f_pass(ZERO_W, 1'b0);
                2'b01:   rsh_s = (rs_amt_s <= W8) ? f_lsr(Val_Rm, rs_amt_s, carry_in)
                                                  : f_pass(ZERO_W, 1'b0);
                2'b10:   rsh_s = f_asr(Val_Rm, (rs_amt_s < W8) ? rs_amt_s : W8, carry_in);
                2'b11:   rsh_s = (ror_amt_s == 8'd0) ? f_pass(Val_Rm, Val_Rm[WIDTH-1])
                                                     : f_ror(Val_Rm, ror_amt_s, carry_in);
                default: rsh_s = f_pass(Val_Rm, carry_in);
            endcase
        end
    end

    // Mode priority: MEM, then immediate rotate, then register shift, then immediate shift.
    always_comb begin
        dec_s = ish_s;
        if (MEM) begin
            dec_s = f_pass(mem_ext_s, carry_in);
        end else if (imm) begin
            dec_s = f_ror(imm_ext_s, rot_s, carry_in);
        end else if (Shift_operand[4]) begin
            dec_s = rsh_s;
        end else begin
            dec_s = ish_s;
        end
    end

    assign out_free_s = !vo_q || out_ready;

    generate
        if (STAGES == 2) begin : g_two
            shf_t s1_q, s1_d;
            logic v1_q, v1_d;

            // Stage 1 holds the decoded funnel; it empties when the output stage takes it.
            always_comb begin
                s1_d = s1_q;
                v1_d = v1_q;
                if (in_valid && in_ready_s) begin
                    s1_d = dec_s;
                    v1_d = 1'b1;
                end else if (out_free_s) begin
                    v1_d = 1'b0;
                end else begin
                    v1_d = v1_q;
                end
            end

            // Stage 1 register.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    v1_q <= 1'b0;
                    s1_q <= '{src: {SW{1'b0}}, amt: 8'd0, left: 1'b0};
                end else begin
                    v1_q <= v1_d;
                    s1_q <= s1_d;
                end
            end

            assign in_ready_s = rst && (!v1_q || out_free_s);
            assign out_load_s = v1_q && out_free_s;
            assign out_src_s  = s1_q;
        end else begin : g_one
            assign in_ready_s = rst && out_free_s;
            assign out_load_s = in_valid && in_ready_s;
            assign out_src_s  = dec_s;
        end
    endgenerate

    // Output stage next state: final select on load, drop valid once consumed.
    always_comb begin
        sel_s  = f_select(out_src_s);
        vo_d   = vo_q;
        val2_d = val2_q;
        co_d   = co_q;
        if (out_load_s) begin
            vo_d   = 1'b1;
            val2_d = sel_s[WIDTH-1:0];
            co_d   = sel_s[WIDTH];
        end else if (out_ready) begin
            vo_d = 1'b0;
        end else begin
            vo_d = vo_q;
        end
    end

    // Output stage register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vo_q   <= 1'b0;
            val2_q <= ZERO_W;
            co_q   <= 1'b0;
        end else begin
            vo_q   <= vo_d;
            val2_q <= val2_d;
            co_q   <= co_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = vo_q;
    assign Val2      = val2_q;
    assign carry_out = co_q;

endmodule

// File: tb/tb_val2_shift_pipe.sv
// Scoreboard bench for val2_shift_pipe (WIDTH=32, STAGES=2): directed operand cases,
// throttled streams, stall stability, reset flush.
module tb_val2_shift_pipe;

    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Val_Rm = 32'd0;
    logic [31:0] Val_Rs = 32'd0;
    logic [11:0] Shift_operand = 12'd0;
    logic        imm = 1'b0;
    logic        MEM = 1'b0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Val2;
    logic        carry_out;

    logic [32:0] sb_q[$];
    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;
    int rdy_idx = 0;

    val2_shift_pipe #(.WIDTH(32), .STAGES(STAGES), .MEM_SEXT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Val_Rm(Val_Rm), .Val_Rs(Val_Rs), .Shift_operand(Shift_operand),
        .imm(imm), .MEM(MEM), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready), .Val2(Val2), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Reference: returns {carry, val2} for WIDTH=32.
    function automatic logic [32:0] ref_op(input logic [31:0] rm, input logic [31:0] rs,
                                           input logic [11:0] so, input logic i_imm,
                                           input logic i_mem, input logic c);
        logic [31:0] v;
        logic [31:0] x;
        logic        co;
        int          s;
        v  = rm;
        co = c;
        if (i_mem) begin
            v  = {{20{so[11]}}, so};
            co = c;
        end else if (i_imm) begin
            s  = 2 * int'(so[11:8]);
            x  = {24'd0, so[7:0]};
            v  = (s == 0) ? x : ((x >> s) | (x << (32 - s)));
            co = (s == 0) ? c : v[31];
        end else if (so[4]) begin
            s = int'(rs[7:0]);
            if (s != 0) begin
                case (so[6:5])
                    2'b00: if (s < 32) begin v = rm << s; co = rm[32-s]; end
                           else if (s == 32) begin v = 32'd0; co = rm[0]; end
                           else begin v = 32'd0; co = 1'b0; end
                    2'b01: if (s < 32) begin v = rm >> s; co = rm[s-1]; end
                           else if (s == 32) begin v = 32'd0; co = rm[31]; end
                           else begin v = 32'd0; co = 1'b0; end
                    2'b10: if (s < 32) begin v = $signed(rm) >>> s; co = rm[s-1]; end
                           else begin v = {32{rm[31]}}; co = rm[31]; end
                    default: begin
                        s = s % 32;
                        if (s == 0) begin v = rm; co = rm[31]; end
                        else begin v = (rm >> s) | (rm << (32 - s)); co = v[31]; end
                    end
                endcase
            end
        end else begin
            s = int'(so[11:7]);
            case (so[6:5])
                2'b00: if (s != 0) begin v = rm << s; co = rm[32-s]; end
                2'b01: if (s == 0) begin v = 32'd0; co = rm[31]; end
                       else begin v = rm >> s; co = rm[s-1]; end
                2'b10: if (s == 0) begin v = {32{rm[31]}}; co = rm[31]; end
                       else begin v = $signed(rm) >>> s; co = rm[s-1]; end
                default: if (s == 0) begin v = {c, rm[31:1]}; co = rm[0]; end
                         else begin v = (rm >> s) | (rm << (32 - s)); co = v[31]; end
            endcase
        end
        return {co, v};
    endfunction

    // Present one request until accepted; expected result is queued on acceptance.
    task automatic send(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] so,
                        input logic i_imm, input logic i_mem, input logic c,
                        input logic [32:0] exp);
        bit ok;
        ok = 1'b0;
        Val_Rm = rm; Val_Rs = rs; Shift_operand = so;
        imm = i_imm; MEM = i_mem; carry_in = c; in_valid = 1'b1;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            #1;
            if (ok) sb_q.push_back(exp);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_val("accept", 64'(ok), 64'd1);
    endtask

    task automatic rand_send();
        logic [31:0] rm, rs, r;
        logic [11:0] so;
        int sel;
        rm  = $urandom;
        rs  = $urandom;
        r   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4) rs[7:0] = 8'($urandom_range(0, 70));
        so = r[11:0];
        send(rm, rs, so, sel == 8, sel == 9, r[12], ref_op(rm, rs, so, sel == 8, sel == 9, r[12]));
    endtask

    // Consumer: out_ready pattern per rdy_mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (rdy_idx % 3 == 0);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            rdy_idx++;
        end
    end

    // Monitor: compares presented output against the queue head every cycle (stall stability).
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb_q.delete();
            end else begin
                check_val("in_ready", 64'(in_ready),
                          64'(!(sb_q.size() == STAGES && !out_ready)));
                if (sb_q.size() == STAGES) check_val("out_valid_full", 64'(out_valid), 64'd1);
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        check_val("spurious_out", 64'(out_valid), 64'd0);
                    end else begin
                        check_val("val2", 64'(Val2), 64'(sb_q[0][31:0]));
                        check_val("carry", 64'(carry_out), 64'(sb_q[0][32]));
                        if (out_ready) void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_val2", 64'(Val2), 64'd0);
        check_val("rst_carry", 64'(carry_out), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Memory offset, latency and single-cycle valid
        send(32'd0, 32'd0, 12'hFFC, 1'b0, 1'b1, 1'b1, {1'b1, 32'hFFFFFFFC});
        for (int i = 1; i < STAGES; i++) begin
            @(negedge clk);
            check_val("lat_early", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_val("lat_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("one_cycle", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Immediate rotate
        send(32'd0, 32'd0, 12'h4FF, 1'b1, 1'b0, 1'b0, {1'b1, 32'hFF000000});
        send(32'd0, 32'd0, 12'h0AB, 1'b1, 1'b0, 1'b1, {1'b1, 32'h000000AB});
        // Immediate shift #0 encodings and LSL #1
        send(32'h80000001, 32'd0, 12'h020, 1'b0, 1'b0, 1'b1, {1'b1, 32'h00000000});
        send(32'h80000001, 32'd0, 12'h040, 1'b0, 1'b0, 1'b1, {1'b1, 32'hFFFFFFFF});
        send(32'h80000001, 32'd0, 12'h060, 1'b0, 1'b0, 1'b1, {1'b1, 32'hC0000000});
        send(32'h80000001, 32'd0, 12'h080, 1'b0, 1'b0, 1'b1, {1'b1, 32'h00000002});
        // Register shifts at the width boundary
        send(32'h0000000F, 32'd32,    12'h010, 1'b0, 1'b0, 1'b0, {1'b1, 32'h00000000});
        send(32'h0000000F, 32'd33,    12'h010, 1'b0, 1'b0, 1'b1, {1'b0, 32'h00000000});
        send(32'h0000000F, 32'h100,   12'h010, 1'b0, 1'b0, 1'b1, {1'b1, 32'h0000000F});
        send(32'h0000000F, 32'h100,   12'h010, 1'b0, 1'b0, 1'b0, {1'b0, 32'h0000000F});
        send(32'h0000000F, 32'd36,    12'h070, 1'b0, 1'b0, 1'b0, {1'b1, 32'hF0000000});
        send(32'h80000000, 32'd32,    12'h070, 1'b0, 1'b0, 1'b0, {1'b1, 32'h80000000});
        send(32'h80000000, 32'd40,    12'h050, 1'b0, 1'b0, 1'b0, {1'b1, 32'hFFFFFFFF});

        // Back-to-back stream with out_ready 1,0,0,1,...
        rdy_idx  = 0;
        rdy_mode = 1;
        for (int k = 0; k < 8; k++) rand_send();
        // Random traffic with random backpressure
        rdy_mode = 2;
        for (int k = 0; k < 48; k++) rand_send();

        // Drain, then flush two in-flight entries with reset
        rdy_mode = 0;
        for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(posedge clk);
        check_val("drain1", 64'(sb_q.size()), 64'd0);
        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        send(32'h12345678, 32'd0, 12'h0AB, 1'b1, 1'b0, 1'b0, {1'b0, 32'h000000AB});
        send(32'h12345678, 32'd0, 12'hFFC, 1'b0, 1'b1, 1'b0, {1'b0, 32'hFFFFFFFC});
        rst = 1'b0;
        Shift_operand = 12'h123; MEM = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("flush_out_valid", 64'(out_valid), 64'd0);
        check_val("flush_val2", 64'(Val2), 64'd0);
        check_val("flush_in_ready", 64'(in_ready), 64'd1);
        rdy_mode = 0;
        repeat (6) @(posedge clk);
        #1;

        rdy_mode = 2;
        for (int k = 0; k < 12; k++) rand_send();
        rdy_mode = 0;
        for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(posedge clk);
        check_val("drain2", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/val2_shift_pipe.md
Name: val2_shift_pipe

Overview:
- Parametrised, pipelined successor to the combinational operand-2 generator.
- Sits between ID/EXE register read and the ALU.
- Computes the Val2 operand and the shifter carry-out with full ARM data-processing semantics:
  - immediate rotate;
  - immediate-amount shifts, including the #0 special encodings (LSR/ASR #32, RRX);
  - register-specified shifts;
  - memory offset (sign-extended).
- Results are buffered behind a valid/ready handshake, with 1 or 2 register stages.

Parameters:
- WIDTH, 32, datapath width. Legal values: 32 or 64.
- STAGES, 1, pipeline register stages. Legal values: 1 or 2. Latency equals STAGES cycles.
- MEM_SEXT, 1, 1 = sign-extend the 12-bit memory offset, 0 = zero-extend it.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-low. Sampled on the rising edge of clk.
- in_valid  in  1  the request below is valid.
- in_ready  out  1  block can accept a request this cycle.
- Val_Rm  in  WIDTH  Rm register value.
- Val_Rs  in  WIDTH  Rs register value (register-specified shift).
- Shift_operand  in  12  instruction bits [11:0].
- imm  in  1  I bit: immediate operand.
- MEM  in  1  load/store offset mode.
- carry_in  in  1  current C flag.
- out_valid  out  1  Val2/carry_out are valid.
- out_ready  in  1  consumer accepts the result.
- Val2  out  WIDTH  operand 2.
- carry_out  out  1  shifter carry-out.

Behaviour:
- Transfer rules:
  - A request is accepted when in_valid && in_ready.
  - A result is delivered when out_valid && out_ready.
- Each stage holds one entry and a valid bit. Stage k loads when it is empty or its contents move on in the same cycle.
- in_ready = !v1 || (downstream of stage 1 ready). The path is combinational through the stages, so full throughput is 1 request per cycle.
- Stall: out_valid=1 && out_ready=0 holds Val2 and carry_out stable. in_ready drops only when every stage is full.
- STAGES=2:
  - Stage 1 registers the decoded shift type, the shift amount (8 bits) and a 2·WIDTH concatenated source.
  - Stage 2 performs the final select.
  - The split point is internal, but the results must be bit-identical to STAGES=1.
- Reset (rst=0 at a clock edge):
  - all valid bits are cleared;
  - out_valid=0, Val2=0, carry_out=0;
  - in_ready=1 from the first cycle after reset.
  - In-flight entries are discarded without being delivered.
  - A request presented during the reset cycle is not accepted.
- Mode priority: MEM > imm > register shift (Shift_operand[4]=1) > immediate shift.
- MEM mode:
  - Val2 = the 12-bit offset, extended per MEM_SEXT.
  - carry_out = carry_in.
- imm mode:
  - rot = 2·Shift_operand[11:8].
  - Val2 = zero-extended Shift_operand[7:0], rotated right by rot mod WIDTH.
  - carry_out = carry_in if rot==0, else Val2[WIDTH-1].
- Immediate shift: amt = Shift_operand[11:7], type = Shift_operand[6:5].
  - LSL:
    - amt=0: Val2=Rm, carry_out=carry_in.
    - otherwise: Val2=Rm<<amt, carry_out=Rm[WIDTH-amt].
  - LSR:
    - amt=0 means a shift by 32: Val2=0, carry_out=Rm[31]. For WIDTH=64 it is a logical shift by 32.
    - otherwise: carry_out=Rm[amt-1].
  - ASR:
    - amt=0 means 32: all bits = Rm[WIDTH-1], carry_out=Rm[WIDTH-1]. For WIDTH=64 it is an arithmetic shift by 32, carry_out=Rm[31].
    - otherwise: carry_out=Rm[amt-1].
  - ROR:
    - amt=0 means RRX: Val2={carry_in, Rm[WIDTH-1:1]}, carry_out=Rm[0].
    - otherwise: rotate right, carry_out=Val2[WIDTH-1].
- Register shift:
  - s = Val_Rs[7:0]. Shift_operand[7] is ignored.
  - s=0 (all types): Val2=Rm, carry_out=carry_in.
  - LSL/LSR:
    - s<WIDTH: normal shift.
    - s==WIDTH: Val2=0, carry_out=Rm[0] for LSL, Rm[WIDTH-1] for LSR.
    - s>WIDTH: Val2=0, carry_out=0.
  - ASR, s>=WIDTH: all bits = sign, carry_out = sign.
  - ROR:
    - effective amount = s mod WIDTH.
    - If that amount is 0 with s≠0: Val2=Rm, carry_out=Rm[WIDTH-1].
- Any mode that produces no defined shifter carry drives carry_out=carry_in, never X.
- No X may propagate to Val2 or carry_out for any legal input.

Test Plan:
- Reset, then MEM=1, Shift_operand=12'hFFC, out_ready=1 -> after STAGES cycles: Val2=32'hFFFFFFFC, carry_out=carry_in, out_valid for exactly 1 cycle.
- imm=1, Shift_operand=12'h4FF (rot=8) -> Val2=32'hFF000000, carry_out=1. Then Shift_operand=12'h0AB, carry_in=1 -> Val2=32'h000000AB, carry_out=1.
- Immediate shift, Rm=32'h80000001, carry_in=1:
  - LSR #0 -> Val2=0, carry_out=1.
  - ASR #0 -> Val2=32'hFFFFFFFF, carry_out=1.
  - ROR #0 (RRX) -> Val2=32'hC0000000, carry_out=1.
  - LSL #1 -> Val2=32'h00000002, carry_out=1.
- Register shift, Rm=32'h0000000F, LSL:
  - Rs=32 -> Val2=0, carry_out=1.
  - Rs=33 -> Val2=0, carry_out=0.
  - Rs=0x100 (low byte 0) -> Val2=32'h0000000F, carry_out=carry_in.
  - Rm=32'h0000000F, ROR Rs=36 -> Val2=32'hF0000000, carry_out=1.
- Back-to-back stream of 8 requests with out_ready toggling 1,0,0,1,...:
  - no request is lost or duplicated; order is preserved;
  - outputs hold stable while stalled;
  - in_ready=0 only when all STAGES entries are full.
- rst asserted while 2 entries are in flight (STAGES=2) -> next cycle out_valid=0, Val2=0, in_ready=1, and the flushed entries never appear.
